// File: rtl/dcache_flush_arbiter_pkg.sv
// rtl/dcache_flush_arbiter_pkg.sv - shared types and defaults for the dcache flush arbiter
package dcache_flush_arbiter_pkg;

    typedef enum logic [1:0] {
        FLUSH_IDLE,
        FLUSH_BUSY,
        FLUSH_SETTLE
    } flush_arb_state_e;

    localparam int unsigned FLUSH_DRAIN_CYCLES = 16;

endpackage

// File: rtl/flush_rr_pick.sv
// rtl/flush_rr_pick.sv - combinational round-robin pick: lowest pending index >= rr_ptr, wrapping
module flush_rr_pick #(
    parameter int unsigned NrReq = 3,
    parameter int unsigned IdxW  = (NrReq > 1) ? $clog2(NrReq) : 1
) (
    input  logic [NrReq-1:0] pending_i,
    input  logic [IdxW-1:0]  rr_ptr_i,
    output logic [IdxW-1:0]  idx_o,
    output logic [NrReq-1:0] onehot_o,
    output logic             valid_o
);

    always_comb begin
        logic [IdxW-1:0] cand;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < NrReq; k++) begin
            cand = IdxW'((32'(rr_ptr_i) + k) % NrReq);
            if (!valid_o && pending_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

    assign onehot_o = valid_o ? (NrReq'(1) << idx_o) : '0;

endmodule

// File: rtl/dcache_flush_arbiter.sv
// rtl/dcache_flush_arbiter.sv - shares the dcache flush port between NrReq requesters
// Define FLUSH_COALESCE_EN to let one flush serve every requester pending at grant time.
module dcache_flush_arbiter
    import dcache_flush_arbiter_pkg::*;
#(
    parameter int unsigned NrReq       = 3,
    parameter int unsigned DrainCycles = FLUSH_DRAIN_CYCLES
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NrReq-1:0]                       req_i,
    output logic [NrReq-1:0]                       ack_o,
    output logic                                   busy_o,
    output logic [((NrReq > 1) ? $clog2(NrReq) : 1)-1:0] active_idx_o,
    output logic                                   flush_dcache_o,
    input  logic                                   flush_dcache_ack_i,
    input  logic                                   cache_busy_i
);

    localparam int unsigned IdxW = (NrReq > 1) ? $clog2(NrReq) : 1;
    localparam int unsigned CntW = $clog2(DrainCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DrainCycles - 1);

    flush_arb_state_e state_q, state_d;
    logic [NrReq-1:0] pending_q, pending_d;
    logic [NrReq-1:0] grant_q, grant_d;
    logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]  active_idx_q, active_idx_d;
    logic [CntW-1:0]  drain_cnt_q, drain_cnt_d;

    logic [IdxW-1:0]  win_idx;
    logic [NrReq-1:0] win_onehot;
    logic             win_valid;

    flush_rr_pick #(
        .NrReq (NrReq),
        .IdxW  (IdxW)
    ) u_pick (
        .pending_i (pending_q),
        .rr_ptr_i  (rr_ptr_q),
        .idx_o     (win_idx),
        .onehot_o  (win_onehot),
        .valid_o   (win_valid)
    );

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        rr_ptr_d       = rr_ptr_q;
        active_idx_d   = active_idx_q;
        drain_cnt_d    = drain_cnt_q;
        ack_o          = '0;
        flush_dcache_o = 1'b0;

        unique case (state_q)
            FLUSH_IDLE: begin
                if (win_valid) begin
`ifdef FLUSH_COALESCE_EN
                    grant_d = pending_q;
`else
                    grant_d = win_onehot;
`endif
                    active_idx_d = win_idx;
                    rr_ptr_d     = (32'(win_idx) == NrReq - 1) ? '0 : win_idx + 1'b1;
                    state_d      = FLUSH_BUSY;
                end
            end
            FLUSH_BUSY: begin
                flush_dcache_o = 1'b1;
                if (flush_dcache_ack_i) begin
                    state_d     = FLUSH_SETTLE;
                    drain_cnt_d = '0;
                end
            end
            FLUSH_SETTLE: begin
                // Any cache activity restarts the idle window from scratch.
                if (cache_busy_i) begin
                    drain_cnt_d = '0;
                end else if (drain_cnt_q == CntLast) begin
                    ack_o   = grant_q;
                    state_d = FLUSH_IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            default: state_d = FLUSH_IDLE;
        endcase

        // A request coinciding with its own ack is a fresh request and stays pending.
        pending_d = (pending_q & ~ack_o) | req_i;
    end

    assign busy_o       = (state_q != FLUSH_IDLE) || (|pending_q);
    assign active_idx_o = active_idx_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= FLUSH_IDLE;
            pending_q    <= '0;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            active_idx_q <= '0;
            drain_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            active_idx_q <= active_idx_d;
            drain_cnt_q  <= drain_cnt_d;
        end
    end

endmodule

// File: tb/tb_dcache_flush_arbiter.sv
// tb/tb_dcache_flush_arbiter.sv - scoreboard bench for dcache_flush_arbiter (NrReq=3, DrainCycles=16)
module tb_dcache_flush_arbiter;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [2:0] req_i = '0;
    logic       flush_dcache_ack_i = 1'b0;
    logic       cache_busy_i = 1'b0;
    logic [2:0] ack_o;
    logic       busy_o;
    logic [1:0] active_idx_o;
    logic       flush_dcache_o;

    dcache_flush_arbiter #(
        .NrReq       (3),
        .DrainCycles (16)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .req_i              (req_i),
        .ack_o              (ack_o),
        .busy_o             (busy_o),
        .active_idx_o       (active_idx_o),
        .flush_dcache_o     (flush_dcache_o),
        .flush_dcache_ack_i (flush_dcache_ack_i),
        .cache_busy_i       (cache_busy_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] ack;
        int         cyc;
    } exp_ack_t;

    exp_ack_t ack_q[$];
    int       idx_q[$];
    exp_ack_t e;
    logic     flush_prev = 1'b0;
    int       fl_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Ack monitor: every nonzero ack_o must match the next expected value and cycle.
    always @(negedge clk_i) begin
        if (rst_ni && ack_o != 3'b000) begin
            if (ack_q.size() == 0) begin
                check("unexpected_ack", 32'(ack_o), 32'd0);
            end else begin
                e = ack_q.pop_front();
                check("ack_value", 32'(ack_o), 32'(e.ack));
                check("ack_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Grant monitor: each new flush must be for the expected requester index.
    always @(negedge clk_i) begin
        if (flush_dcache_o && !flush_prev) begin
            if (idx_q.size() == 0) check("unexpected_flush", 32'(active_idx_o), 32'hffff);
            else check("grant_idx", 32'(active_idx_o), 32'(idx_q.pop_front()));
        end
        flush_prev = flush_dcache_o;
    end

    // Cache model: acks in the fourth cycle that flush_dcache_o is high.
    initial begin
        forever begin
            @(negedge clk_i);
            if (flush_dcache_ack_i) begin
                flush_dcache_ack_i = 1'b0;
                fl_cnt = 0;
            end else if (flush_dcache_o) begin
                fl_cnt++;
                if (fl_cnt == 4) flush_dcache_ack_i = 1'b1;
            end else begin
                fl_cnt = 0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_req(input logic [2:0] v);
        req_i = v;
        step(1);
        req_i = '0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        step(2);
        rst_ni = 1'b1;
        step(1);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((ack_q.size() != 0 || idx_q.size() != 0 || busy_o) && n < 300) begin
            step(1);
            n++;
        end
        check({name, "_drained"}, 32'(ack_q.size() + idx_q.size()), 32'd0);
        check({name, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int t;

        // Reset state
        step(1);
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_idx", 32'(active_idx_o), 32'd0);
        check("rst_flush", 32'(flush_dcache_o), 32'd0);
        rst_ni = 1'b1;
        step(1);

        // Single request: flush t+2..t+5, cache ack at t+5, ack_o at t+21
        t = cyc;
        ack_q.push_back('{3'b001, t + 21});
        idx_q.push_back(0);
        pulse_req(3'b001);
        check("t1_flush_t1", 32'(flush_dcache_o), 32'd0);
        check("t1_busy_t1", 32'(busy_o), 32'd1);
        step(1);
        check("t1_flush_t2", 32'(flush_dcache_o), 32'd1);
        step(3);
        check("t1_flush_t5", 32'(flush_dcache_o), 32'd1);
        step(1);
        check("t1_flush_t6", 32'(flush_dcache_o), 32'd0);
        wait_done("t1");

        // All three request together
        do_reset();
        t = cyc;
`ifdef FLUSH_COALESCE_EN
        ack_q.push_back('{3'b111, t + 21});
        idx_q.push_back(0);
`else
        ack_q.push_back('{3'b001, t + 21});
        ack_q.push_back('{3'b010, t + 42});
        ack_q.push_back('{3'b100, t + 63});
        idx_q.push_back(0);
        idx_q.push_back(1);
        idx_q.push_back(2);
`endif
        pulse_req(3'b111);
        wait_done("t2");

        // Pointer position after that round shows up in the next grant order
        t = cyc;
`ifdef FLUSH_COALESCE_EN
        ack_q.push_back('{3'b101, t + 21});
        idx_q.push_back(2);
`else
        ack_q.push_back('{3'b001, t + 21});
        ack_q.push_back('{3'b100, t + 42});
        idx_q.push_back(0);
        idx_q.push_back(2);
`endif
        pulse_req(3'b101);
        wait_done("t3");

        // Cache busy for 2 cycles while drain_cnt_q==10: settle starts t+6, ack at t+33
        do_reset();
        t = cyc;
        ack_q.push_back('{3'b001, t + 33});
        idx_q.push_back(0);
        pulse_req(3'b001);
        step(15);
        cache_busy_i = 1'b1;
        step(2);
        cache_busy_i = 1'b0;
        wait_done("t4");

        // Request for idx 1 during the idx 0 flush waits for its own round
        do_reset();
        t = cyc;
        ack_q.push_back('{3'b001, t + 21});
        ack_q.push_back('{3'b010, t + 42});
        idx_q.push_back(0);
        idx_q.push_back(1);
        pulse_req(3'b001);
        step(2);
        pulse_req(3'b010);
        wait_done("t5");

        // Reset during SETTLE: outputs drop at once and no ack appears
        do_reset();
        idx_q.push_back(1);
        pulse_req(3'b010);
        step(10);
        rst_ni = 1'b0;
        #1;
        check("t6_rst_flush", 32'(flush_dcache_o), 32'd0);
        check("t6_rst_ack", 32'(ack_o), 32'd0);
        check("t6_rst_busy", 32'(busy_o), 32'd0);
        check("t6_rst_idx", 32'(active_idx_o), 32'd0);
        step(2);
        rst_ni = 1'b1;
        step(1);
        t = cyc;
        ack_q.push_back('{3'b100, t + 21});
        idx_q.push_back(2);
        pulse_req(3'b100);
        wait_done("t6");

        step(5);
        check("final_ack_queue", 32'(ack_q.size()), 32'd0);
        check("final_idx_queue", 32'(idx_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
